// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer
//
// Sequences one output-stationary matrix-multiply pass on a ROWS x COLS
// systolic array of MAC processing elements. It clears the accumulators,
// streams k_len operand beats from the edge buffers, drains the skewed
// wavefront, pulses the PE capture, and then unloads the C tile one row per
// handshake.
//
// Ports:
//   clk          single rising-edge clock
//   rst          synchronous active-high reset (aborts a pass, no done)
//   start        begin a pass; only honoured in IDLE
//   k_len        inner dimension (beats to feed), latched with start
//   op_valid     edge buffers hold one A and one B beat
//   op_rd        pop one beat from the edge buffers this cycle
//   pe_clear     clear all PE accumulators and C registers
//   pe_en        array advance enable
//   pe_zero      inject zeros at the array edges instead of buffer data
//   pe_finished  PEs copy accumulator into their C output register
//   out_valid    C row out_row is on the array output bus
//   out_row      index of the C row being unloaded
//   out_ready    downstream accepts the current row
//   busy         pass in progress
//   done         one-cycle pulse when the pass completes

module mac_array_sequencer #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int KW   = 8,
   parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] k_len,
   input  logic          op_valid,
   output logic          op_rd,
   output logic          pe_clear,
   output logic          pe_en,
   output logic          pe_zero,
   output logic          pe_finished,
   output logic          out_valid,
   output logic [RW-1:0] out_row,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CLEAR   = 3'd1;
   localparam logic [2:0] FEED    = 3'd2;
   localparam logic [2:0] DRAIN   = 3'd3;
   localparam logic [2:0] CAPTURE = 3'd4;
   localparam logic [2:0] OUTPUT  = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   // The drain counter must reach ROWS+COLS-2, which always fits in
   // clog2(ROWS+COLS) bits because ROWS+COLS is at least 2.
   localparam int            DW         = $clog2(ROWS + COLS);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(ROWS + COLS - 2);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

   logic [2:0]    state;
   logic [KW-1:0] k_reg;
   logic [KW-1:0] beat_cnt;
   logic [KW-1:0] k_last;
   logic [DW-1:0] drain_cnt;
   logic [RW-1:0] row_cnt;

   // Comparing against k_reg-1 rather than counting up to k_reg keeps the
   // counter at KW bits while still handling k_reg = 2^KW-1 without wrapping.
   // FEED is only entered with k_reg != 0, so k_last never underflows there.
   assign k_last = k_reg - KW'(1);

   // Main sequencing state machine with its beat, drain and row counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k_reg     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         row_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  k_reg <= k_len;
                  state <= CLEAR;
               end
            end
            CLEAR: begin
               beat_cnt  <= '0;
               drain_cnt <= '0;
               row_cnt   <= '0;
               state     <= (k_reg != '0) ? FEED : CAPTURE;
            end
            FEED: begin
               // A stall still advances the array with a zero beat, so only
               // real pops count towards k_reg.
               if (op_valid) begin
                  if (beat_cnt == k_last) begin
                     beat_cnt <= '0;
                     state    <= DRAIN;
                  end else begin
                     beat_cnt <= beat_cnt + KW'(1);
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  drain_cnt <= '0;
                  state     <= CAPTURE;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
            CAPTURE: begin
               row_cnt <= '0;
               state   <= OUTPUT;
            end
            OUTPUT: begin
               if (out_ready) begin
                  if (row_cnt == ROW_LAST) begin
                     row_cnt <= '0;
                     state   <= DONE;
                  end else begin
                     row_cnt <= row_cnt + RW'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs decode from registered state; only op_rd and pe_zero look at
   // op_valid so a stalled FEED cycle becomes a zero beat instead of a pop.
   always_comb begin
      op_rd       = (state == FEED) && op_valid;
      pe_clear    = (state == CLEAR);
      pe_en       = (state == FEED) || (state == DRAIN);
      pe_zero     = (state == DRAIN) || ((state == FEED) && !op_valid);
      pe_finished = (state == CAPTURE);
      out_valid   = (state == OUTPUT);
      out_row     = row_cnt;
      busy        = (state != IDLE);
      done        = (state == DONE);
   end

endmodule

// File: tb/tb_mac_array_sequencer.sv
// tb_mac_array_sequencer
//
// Directed bench for mac_array_sequencer with ROWS=COLS=4, KW=8. Each cycle
// the whole output set is packed into one vector and compared against a
// hand-derived phase for that cycle, counted from the edge that samples start.

module tb_mac_array_sequencer;

   localparam int P_IDLE  = 0;
   localparam int P_CLEAR = 1;
   localparam int P_FEED  = 2;
   localparam int P_STALL = 3;
   localparam int P_DRAIN = 4;
   localparam int P_CAP   = 5;
   localparam int P_OUT   = 6;
   localparam int P_DONE  = 7;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] k_len;
   logic       op_valid;
   logic       op_rd;
   logic       pe_clear;
   logic       pe_en;
   logic       pe_zero;
   logic       pe_finished;
   logic       out_valid;
   logic [1:0] out_row;
   logic       out_ready;
   logic       busy;
   logic       done;

   int checks;
   int failures;

   mac_array_sequencer #(
      .ROWS(4),
      .COLS(4),
      .KW(8),
      .RW(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .k_len(k_len),
      .op_valid(op_valid),
      .op_rd(op_rd),
      .pe_clear(pe_clear),
      .pe_en(pe_en),
      .pe_zero(pe_zero),
      .pe_finished(pe_finished),
      .out_valid(out_valid),
      .out_row(out_row),
      .out_ready(out_ready),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit order: {op_rd, pe_clear, pe_en, pe_zero, pe_finished, out_valid,
   // out_row[1:0], busy, done}.
   function automatic logic [9:0] expVec(input int ph, input int row);
      logic [9:0] v;
      v = '0;
      case (ph)
         P_CLEAR: v = 10'b0100000010;
         P_FEED:  v = 10'b1010000010;
         P_STALL: v = 10'b0011000010;
         P_DRAIN: v = 10'b0011000010;
         P_CAP:   v = 10'b0000100010;
         P_OUT:   v = {6'b000001, row[1:0], 2'b10};
         P_DONE:  v = 10'b0000000011;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Phase of a stall-free pass with k>0 at cycle c after the start edge:
   // CLEAR 1, FEED 2..k+1, DRAIN k+2..k+8, CAPTURE k+9, OUTPUT k+10..k+13,
   // DONE k+14.
   function automatic void stdPhase(input int c, input int k, output int ph, output int row);
      row = 0;
      if (c == 1)            ph = P_CLEAR;
      else if (c <= k + 1)   ph = P_FEED;
      else if (c <= k + 8)   ph = P_DRAIN;
      else if (c == k + 9)   ph = P_CAP;
      else if (c <= k + 13) begin
         ph  = P_OUT;
         row = c - (k + 10);
      end
      else if (c == k + 14)  ph = P_DONE;
      else                   ph = P_IDLE;
   endfunction

   // Advance to the next cycle and drive that cycle's inputs, then let the
   // combinational outputs settle before any check.
   task automatic applyStimulus(input logic s, input logic [7:0] k, input logic v, input logic r);
      @(posedge clk);
      #1;
      start     = s;
      k_len     = k;
      op_valid  = v;
      out_ready = r;
      #1;
   endtask

   task automatic checkOutput(input string tag, input int ph, input int row);
      logic [9:0] obs;
      logic [9:0] exp;
      obs = {op_rd, pe_clear, pe_en, pe_zero, pe_finished, out_valid, out_row, busy, done};
      exp = expVec(ph, row);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      int ph;
      int row;
      int rd_count;
      int t2 [20];
      logic r4 [7];

      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      start     = 1'b0;
      k_len     = '0;
      op_valid  = 1'b0;
      out_ready = 1'b0;

      // Reset: all outputs low once reset has been sampled and released.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("reset", P_IDLE, 0);

      // Test 1: k=3, no stalls, out_ready always high; done in cycle 17.
      $display("[TB] test 1: k_len=3 stall-free pass");
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b1);
      checkOutput("t1_c0", P_IDLE, 0);
      for (int c = 1; c <= 18; c++) begin
         applyStimulus(1'b0, 8'd3, 1'b1, 1'b1);
         stdPhase(c, 3, ph, row);
         checkOutput($sformatf("t1_c%0d", c), ph, row);
      end

      // Test 2: k=3 with op_valid low in cycles 3 and 5; done in cycle 19.
      $display("[TB] test 2: k_len=3 with operand stalls");
      t2 = '{P_CLEAR, P_FEED, P_STALL, P_FEED, P_STALL, P_FEED,
             P_DRAIN, P_DRAIN, P_DRAIN, P_DRAIN, P_DRAIN, P_DRAIN, P_DRAIN,
             P_CAP, P_OUT, P_OUT, P_OUT, P_OUT, P_DONE, P_IDLE};
      rd_count = 0;
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b1);
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(1'b0, 8'd3, (c != 3) && (c != 5), 1'b1);
         if (op_rd === 1'b1) rd_count++;
         checkOutput($sformatf("t2_c%0d", c), t2[c-1], (c >= 15 && c <= 18) ? c - 15 : 0);
      end
      checks++;
      assert (rd_count === 3) else begin
         failures++;
         $error("[TB] FAIL t2_rd_count observed=%0d expected=3", rd_count);
      end

      // Test 3: k=0 goes CLEAR -> CAPTURE; done in cycle 7.
      $display("[TB] test 3: k_len=0");
      applyStimulus(1'b1, 8'd0, 1'b1, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
         if (c == 1)      ph = P_CLEAR;
         else if (c == 2) ph = P_CAP;
         else if (c <= 6) ph = P_OUT;
         else if (c == 7) ph = P_DONE;
         else             ph = P_IDLE;
         checkOutput($sformatf("t3_c%0d", c), ph, (c >= 3 && c <= 6) ? c - 3 : 0);
      end

      // Test 4: k=0, out_ready 1,0,0,1,1,0,1 across OUTPUT cycles 3..9.
      $display("[TB] test 4: out_ready back-pressure");
      r4 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      applyStimulus(1'b1, 8'd0, 1'b1, 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
      checkOutput("t4_c1", P_CLEAR, 0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
      checkOutput("t4_c2", P_CAP, 0);
      for (int c = 3; c <= 9; c++) begin
         applyStimulus(1'b0, 8'd0, 1'b1, r4[c-3]);
         case (c)
            3:       row = 0;
            4, 5, 6: row = 1;
            7:       row = 2;
            default: row = 3;
         endcase
         checkOutput($sformatf("t4_c%0d", c), P_OUT, row);
      end
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
      checkOutput("t4_c10", P_DONE, 0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
      checkOutput("t4_c11", P_IDLE, 0);

      // Test 5: start during FEED (k=7) and in DONE (k=5) are ignored; the
      // start in the following IDLE cycle latches k=2.
      $display("[TB] test 5: ignored starts");
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b1);
      for (int c = 1; c <= 17; c++) begin
         if (c == 3)       applyStimulus(1'b1, 8'd7, 1'b1, 1'b1);
         else if (c == 17) applyStimulus(1'b1, 8'd5, 1'b1, 1'b1);
         else              applyStimulus(1'b0, 8'd3, 1'b1, 1'b1);
         stdPhase(c, 3, ph, row);
         checkOutput($sformatf("t5a_c%0d", c), ph, row);
      end
      applyStimulus(1'b1, 8'd2, 1'b1, 1'b1);
      checkOutput("t5_idle_after_done", P_IDLE, 0);
      for (int c = 1; c <= 17; c++) begin
         applyStimulus(1'b0, 8'd9, 1'b1, 1'b1);
         stdPhase(c, 2, ph, row);
         checkOutput($sformatf("t5b_c%0d", c), ph, row);
      end

      // Test 6: reset in DRAIN cycle 7 aborts without done; a k=2 pass then
      // completes in 16 cycles.
      $display("[TB] test 6: reset during DRAIN");
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b1);
      for (int c = 1; c <= 7; c++) begin
         applyStimulus(1'b0, 8'd3, 1'b1, 1'b1);
         stdPhase(c, 3, ph, row);
         checkOutput($sformatf("t6a_c%0d", c), ph, row);
      end
      rst = 1'b1;
      applyStimulus(1'b0, 8'd3, 1'b1, 1'b1);
      rst = 1'b0;
      #1;
      checkOutput("t6_after_rst", P_IDLE, 0);
      applyStimulus(1'b1, 8'd2, 1'b1, 1'b1);
      checkOutput("t6_idle_start", P_IDLE, 0);
      for (int c = 1; c <= 17; c++) begin
         applyStimulus(1'b0, 8'd2, 1'b1, 1'b1);
         stdPhase(c, 2, ph, row);
         checkOutput($sformatf("t6b_c%0d", c), ph, row);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
